// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : present_pkg
//  Description : Shared PRESENT definitions: datapath widths, the round-FSM
//                state encoding and the pLayer bit permutation. The full-round
//                core uses the pLayer helper too.
//  Revision    : 1.0 - initial release
// ============================================================================
package present_pkg;

   localparam int STATE_W  = 64;
   localparam int NIBBLE_W = 4;

   // Round FSM state encoding
   typedef logic [1:0] fsm_state_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUB  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // pLayer: bit i moves to 16*i mod 63. Bit 63 is a fixed point.
   function automatic logic [STATE_W-1:0] present_player(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] p;
      p = '0;
      for (int i = 0; i < STATE_W - 1; i++) begin
         p[(16 * i) % 63] = s[i];
      end
      p[STATE_W-1] = s[STATE_W-1];
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
//  Module      : sbox
//  Description : 4-bit PRESENT S-box (combinational) with one scan flop
//                chained in by the parent.
//  Ports       : clk   - scan flop clock
//                din   - nibble in
//                dout  - substituted nibble
//                scand - scan data in
//                scanq - scan data out (one clock of latency, not reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox (
   input  logic       clk,
   input  logic [3:0] din,
   output logic [3:0] dout,
   input  logic       scand,
   output logic       scanq
);

   always_comb begin
      dout = 4'h0;
      case (din)
         4'h0: dout = 4'hC;
         4'h1: dout = 4'h5;
         4'h2: dout = 4'h6;
         4'h3: dout = 4'hB;
         4'h4: dout = 4'h9;
         4'h5: dout = 4'h0;
         4'h6: dout = 4'hA;
         4'h7: dout = 4'hD;
         4'h8: dout = 4'h3;
         4'h9: dout = 4'hE;
         4'hA: dout = 4'hF;
         4'hB: dout = 4'h8;
         4'hC: dout = 4'h4;
         4'hD: dout = 4'h7;
         4'hE: dout = 4'h1;
         4'hF: dout = 4'h2;
         default: dout = 4'h0;
      endcase
   end

   // Scan flop is deliberately outside the functional reset domain.
   always_ff @(posedge clk) begin
      scanq <= scand;
   end

endmodule
`default_nettype wire

// File: rtl/present_sp_layer.sv
`default_nettype none
// ============================================================================
//  Module      : present_sp_layer
//  Description : Serial PRESENT substitution/permutation layer. Loads
//                state ^ key, substitutes LANES nibbles per cycle through the
//                sbox lanes while rotating a 64-bit shift register, then
//                presents pLayer(sreg) until downstream accepts it.
//  Parameters  : LANES      - sbox instances (1, 2, 4, 8 or 16)
//  Ports       : clk, rst_n - clock, asynchronous active-low reset
//                in_valid / in_ready / in_state / in_key - input handshake
//                out_valid / out_ready / out_state       - output handshake
//                scand / scanq - scan chain through the sbox lanes
//  Revision    : 1.0 - initial release
// ============================================================================
module present_sp_layer
   import present_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   input  logic [STATE_W-1:0] in_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   input  logic               scand,
   output logic               scanq
);

   localparam int         N        = 16 / LANES;
   localparam int         SHIFT    = NIBBLE_W * LANES;
   localparam logic [3:0] CNT_LAST = 4'(N - 1);

   fsm_state_t         state;
   logic [3:0]         cnt;
   logic [STATE_W-1:0] sreg;
   logic [STATE_W-1:0] sreg_next;
   logic [SHIFT-1:0]   sub_out;
   logic [LANES:0]     scan_chain;

   assign scan_chain[0] = scand;
   assign scanq         = scan_chain[LANES];

   // Lane j always works on the lowest nibbles of the register, so after
   // N shifts every nibble has passed through a lane exactly once.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      sbox u_sbox (
         .clk   (clk),
         .din   (sreg[NIBBLE_W*j +: NIBBLE_W]),
         .dout  (sub_out[NIBBLE_W*j +: NIBBLE_W]),
         .scand (scan_chain[j]),
         .scanq (scan_chain[j+1])
      );
   end

   // Substituted nibbles re-enter at the top; with all 16 lanes the whole
   // register is replaced in one step.
   if (LANES == 16) begin : g_full_width
      assign sreg_next = sub_out;
   end else begin : g_partial_width
      assign sreg_next = {sub_out, sreg[STATE_W-1:SHIFT]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         sreg  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sreg  <= in_state ^ in_key;
                  cnt   <= 4'd0;
                  state <= ST_SUB;
               end
            end
            ST_SUB: begin
               sreg <= sreg_next;
               cnt  <= cnt + 4'd1;
               if (cnt == CNT_LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign out_state = present_player(sreg);

endmodule
`default_nettype wire
